// File: rtl/seq_detector_prog_if.sv
// Bundle of serial-data, configuration and result signals for seq_detector_prog.
// The master drives stream and configuration; the slave (detector) returns results.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic                 sequence_in;
    logic                 sequence_valid;
    logic                 cfg_load;
    logic [MAX_LEN-1:0]   cfg_pattern;
    logic [LEN_W-1:0]     cfg_len;
    logic                 cfg_overlap;
    logic                 detector_out;
    logic [CNT_W-1:0]     match_count;
    logic                 cfg_err;

    modport master (
        output sequence_in, sequence_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  detector_out, match_count, cfg_err
    );

    modport slave (
        input  sequence_in, sequence_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output detector_out, match_count, cfg_err
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable Moore sequence detector: matches a serial stream against a
// loadable 1..MAX_LEN-bit pattern, overlapping or non-overlapping, with a
// registered one-cycle match pulse and a saturating match counter.
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    seq_detector_prog_if.slave    bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [1:0] UNCFG  = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] SEARCH = 2'd2;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN:0] ONE_W     = (MAX_LEN + 1)'(1);

    logic [1:0]          state_q, state_d;
    logic [MAX_LEN-1:0]  pat_q, pat_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                ovl_q, ovl_d;
    logic [MAX_LEN-1:0]  hist_q, hist_d;
    logic [LEN_W-1:0]    fill_q, fill_d;
    logic                det_q, det_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [MAX_LEN-1:0]  hist_shift;
    logic [LEN_W-1:0]    fill_inc;
    logic [MAX_LEN:0]    mask_w;
    logic                match;
    logic                len_ok;

    // Saturating increment so the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Match evaluation on the history as it will look after this sample.
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], bus.sequence_in};
        fill_inc   = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
        // One extra bit keeps len == MAX_LEN from overflowing the shift.
        mask_w     = (ONE_W << len_q) - ONE_W;
        match      = (state_q != UNCFG) && (fill_inc == len_q) &&
                     (({1'b0, hist_shift ^ pat_q} & mask_w) == '0);
        len_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);
    end

    // Next-state: configuration load wins over a coincident sample.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        det_d   = 1'b0;
        if (bus.cfg_load) begin
            pat_d  = bus.cfg_pattern;
            len_d  = bus.cfg_len;
            ovl_d  = bus.cfg_overlap;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            if (len_ok) begin
                err_d   = 1'b0;
                state_d = FILL;
            end else begin
                err_d   = 1'b1;
                state_d = UNCFG;
            end
        end else if (bus.sequence_valid) begin
            hist_d = hist_shift;
            if (match) begin
                det_d = 1'b1;
                cnt_d = sat_inc(cnt_q);
                if (ovl_q) begin
                    fill_d  = len_q;
                    state_d = SEARCH;
                end else begin
                    // Non-overlapping: the matched bits cannot start a new match.
                    fill_d  = '0;
                    state_d = FILL;
                end
            end else begin
                fill_d = fill_inc;
                if ((state_q != UNCFG) && (fill_inc == len_q)) begin
                    state_d = SEARCH;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.detector_out = det_q;
    assign bus.match_count  = cnt_q;
    assign bus.cfg_err      = err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: stimulus pushes expected pulses
// (cycle and count) into a queue; a monitor pops them as pulses appear.
module tb_seq_detector_prog;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    seq_detector_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    task automatic send(input logic b, input bit exp, input int cnt);
        @(negedge clock);
        bus.cfg_load       = 1'b0;
        bus.sequence_valid = 1'b1;
        bus.sequence_in    = b;
        if (exp) q.push_back('{cyc + 1, cnt});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bus.cfg_load       = 1'b0;
            bus.sequence_valid = 1'b0;
        end
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input int l, input logic o,
                        input logic v, input logic b);
        @(negedge clock);
        bus.cfg_load       = 1'b1;
        bus.cfg_pattern    = p;
        bus.cfg_len        = 4'(l);
        bus.cfg_overlap    = o;
        bus.sequence_valid = v;
        bus.sequence_in    = b;
    endtask

    // Monitor: every pulse must match the head of the queue, every due entry must pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (bus.detector_out) begin
                checks++;
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    check("match_count_at_pulse", int'(bus.match_count), e.cnt);
                end else begin
                    fails++;
                    $display("FAIL unexpected_pulse: detector_out=1 required=0 cycle=%0d", cyc);
                end
            end else if (q.size() > 0 && q[0].cyc == cyc) begin
                checks++;
                fails++;
                $display("FAIL missing_pulse: detector_out=0 required=1 cycle=%0d", cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.sequence_in    = 1'b0;
        bus.sequence_valid = 1'b0;
        bus.cfg_load       = 1'b0;
        bus.cfg_pattern    = '0;
        bus.cfg_len        = '0;
        bus.cfg_overlap    = 1'b0;

        // Reset held with stimulus toggling, including a would-be valid load.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus.sequence_valid = 1'b1;
            bus.sequence_in    = i[0];
            bus.cfg_load       = (i == 1);
            bus.cfg_pattern    = 8'h01;
            bus.cfg_len        = 4'd1;
            bus.cfg_overlap    = 1'b1;
        end
        check("rst_detector_out", int'(bus.detector_out), 0);
        check("rst_match_count", int'(bus.match_count), 0);
        check("rst_cfg_err", int'(bus.cfg_err), 0);
        @(negedge clock);
        bus.cfg_load       = 1'b0;
        bus.sequence_valid = 1'b0;
        reset              = 1'b1;

        // Unconfigured: no detection.
        send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
        idle(1);
        check("uncfg_count", int'(bus.match_count), 0);

        // Overlapping 1011.
        load(8'b0000_1011, 4, 1'b1, 1'b0, 1'b0);
        send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 1, 1);
        send(0, 0, 0); send(1, 0, 0); send(1, 1, 2);
        idle(1);
        check("ovl_count", int'(bus.match_count), 2);
        check("ovl_cfg_err", int'(bus.cfg_err), 0);

        // Non-overlapping 1011.
        load(8'b0000_1011, 4, 1'b0, 1'b0, 1'b0);
        send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 1, 1);
        send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
        idle(1);
        check("novl_count", int'(bus.match_count), 1);

        // 1110 with a 3-cycle valid gap inside the stream.
        load(8'b0000_1110, 4, 1'b1, 1'b0, 1'b0);
        send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
        idle(3);
        send(1, 0, 0); send(0, 1, 1); send(1, 0, 0); send(0, 0, 0); send(0, 0, 0);
        idle(1);
        check("gap_count", int'(bus.match_count), 1);

        // Illegal lengths.
        load(8'h00, 0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("len0_cfg_err", int'(bus.cfg_err), 1);
        send(0, 0, 0); send(0, 0, 0); send(1, 0, 0);
        idle(1);
        check("len0_count", int'(bus.match_count), 0);
        load(8'hFF, 9, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("len9_cfg_err", int'(bus.cfg_err), 1);
        send(1, 0, 0); send(1, 0, 0);

        // Full-length pattern: only the MAX_LEN-th one matches.
        load(8'hFF, MAX_LEN, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("full_cfg_err", int'(bus.cfg_err), 0);
        for (int i = 1; i <= MAX_LEN; i++) send(1, (i == MAX_LEN), 1);
        idle(1);
        check("full_count", int'(bus.match_count), 1);

        // Load coincident with a valid '1': that sample must be dropped.
        load(8'b0000_0010, 2, 1'b1, 1'b1, 1'b1);
        send(0, 0, 0); send(1, 0, 0); send(0, 1, 1);
        idle(1);
        check("coinc_count", int'(bus.match_count), 1);

        // Saturation at 2^CNT_W-1, then asynchronous reset mid-cycle.
        load(8'b0000_0001, 1, 1'b1, 1'b0, 1'b0);
        send(1, 1, 1); send(1, 1, 2); send(1, 1, 3); send(1, 1, 3); send(1, 1, 3);
        @(posedge clock);
        #3;
        check("sat_det_before_rst", int'(bus.detector_out), 1);
        check("sat_count_before_rst", int'(bus.match_count), 3);
        reset = 1'b0;
        #1;
        check("async_rst_det", int'(bus.detector_out), 0);
        check("async_rst_count", int'(bus.match_count), 0);
        @(negedge clock);
        bus.sequence_valid = 1'b0;
        reset              = 1'b1;
        send(1, 0, 0); send(1, 0, 0);
        idle(2);
        check("post_rst_count", int'(bus.match_count), 0);
        check("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Parametrised, runtime-programmable successor to the fixed-pattern Moore sequence detector. It compares a serial bit stream against a loadable pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping detection. It raises a registered (Moore) one-cycle `detector_out` pulse per match and keeps a saturating match counter. It sits between a serial bit source with a sample qualifier and the downstream event logic.

## Interface

**Parameters**
- MAX_LEN, default 8: maximum pattern length in bits (≥ 2).
- CNT_W, default 8: width of the match counter.

**Ports**
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset (0 = in reset).
- sequence_in, in, 1: serial data bit.
- sequence_valid, in, 1: `sequence_in` is sampled on an edge only when this is 1.
- cfg_load, in, 1: latch configuration on this edge.
- cfg_pattern, in, MAX_LEN: pattern; `cfg_pattern[cfg_len-1]` is the first bit received, `cfg_pattern[0]` the last.
- cfg_len, in, $clog2(MAX_LEN+1): pattern length.
- cfg_overlap, in, 1: 1 = overlapping detection, 0 = non-overlapping.
- detector_out, out, 1: registered match pulse.
- match_count, out, CNT_W: saturating match count.
- cfg_err, out, 1: last load had an illegal length.

## Operation

**State machine:** UNCFG, FILL, SEARCH.
- UNCFG: no detection is done. Samples shift into history but never match.
- FILL: fewer than `len` valid bits have been seen since load or last non-overlap match.
- SEARCH: `fill == len`. A match is evaluated on every sample.

**Internal registers:** `pat`, `len`, `ovl`, `hist[MAX_LEN]`, `fill` (saturates at `len`).

**cfg_load = 1:**
- Latches pattern, length and overlap mode.
- Clears `hist`, `fill` and `match_count`.
- Drives `detector_out` to 0.
- If `1 ≤ cfg_len ≤ MAX_LEN`: `cfg_err` ← 0, go to FILL.
- Otherwise: `cfg_err` ← 1, go to UNCFG.
- cfg_load has priority over a simultaneous `sequence_valid`; that sample is dropped.

**Sample edge (sequence_valid = 1, cfg_load = 0):**
- `hist` ← {`hist[MAX_LEN-2:0]`, `sequence_in`}.
- `fill'` = min(`fill`+1, `len`).
- Match if state ≠ UNCFG, `fill'` == `len`, and the low `len` bits of the new `hist` equal the low `len` bits of `pat`.
- On match:
  - `detector_out` ← 1.
  - `match_count` increments, saturating at 2^CNT_W−1.
  - If `ovl` = 0: `fill` ← 0 and state goes to FILL.
  - If `ovl` = 1: `fill` stays at `len` and state stays SEARCH.
- No match: `detector_out` ← 0 and `fill` ← `fill'`.
- State becomes SEARCH when `fill'` reaches `len`.

**Idle edge (sequence_valid = 0):** `hist`, `fill`, state and count hold; `detector_out` ← 0.

**Arithmetic:** the compare mask is `(1<<len)-1`, computed with MAX_LEN+1 bits so that `len` = MAX_LEN does not overflow.

## Timing

**Reset values** (asserted asynchronously, held until reset = 1):
- state = UNCFG
- `pat` = 0, `len` = 0, `ovl` = 0
- `hist` = 0, `fill` = 0
- `detector_out` = 0, `match_count` = 0, `cfg_err` = 0

**Latency and pulse width:**
- `detector_out` rises on the edge that samples the final pattern bit: one cycle after that bit is presented.
- It is high for exactly one clock per match.
- `match_count` updates on the same edge as `detector_out`.

**Gaps:** gaps in `sequence_valid` do not break a partial match; only valid samples count.

**Config and reset timing:**
- Configuration takes effect for samples on edges after the load edge.
- Reset mid-stream discards any partial match immediately; the block stays in UNCFG until the next valid cfg_load.

**Throughput:** one sample per clock, with no back-pressure.

## Test plan

- Reset: hold reset = 0 with stimulus toggling -> all outputs 0 and no pulses. After release, with no cfg_load, stream 1,0,1,1 -> `detector_out` stays 0.
- Overlap: load pattern 1011 (`cfg_pattern` = 8'b0000_1011), `cfg_len` = 4, `cfg_overlap` = 1; stream 1,0,1,1,0,1,1 -> pulses after the 4th and 7th samples; `match_count` = 2.
- Non-overlap: same pattern and stream with `cfg_overlap` = 0 -> single pulse after the 4th sample; `match_count` = 1.
- Gaps and reference stream: load 1110, len 4, overlap 1. Stream 1,1,1,1,0,1,0,0 with `sequence_valid` deasserted for 3 cycles between the 3rd and 4th bits -> exactly one pulse, after the 5th valid sample.
- Boundaries:
  - `cfg_len` = 0 -> `cfg_err` = 1, no matches.
  - `cfg_len` = MAX_LEN with an all-ones pattern and MAX_LEN ones -> pulse on the MAX_LEN-th sample.
  - cfg_load coincident with a valid sample -> that sample is ignored.
- Saturation and async reset: CNT_W = 2, pattern 1, len 1, overlap 1, five 1s -> five pulses; `match_count` reaches 3 and holds. Assert reset between clock edges -> `match_count` and `detector_out` go to 0 immediately.
